fmap_streamer: RTL

Feature-map source for the convolution layers. Buffers one CHANNEL-deep input feature map, loaded word by word in channel-major order. On each start request it replays the map in raster order, presenting all CHANNEL pixel values of one (row, col) position in parallel with one valid strobe. This is the transmit end of the per-channel pixel-stream interface that the 3D convolution kernels consume, and it can replay the stored map any number of times so every output filter sees the same input.

---
 rtl/fmap_streamer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/fmap_streamer.sv
// Feature-map buffer: loads CHANNEL banks in channel-major order, then replays the map in
// raster order with all channels in parallel. Optional zero border: FMAP_STREAMER_PAD_EN.
module fmap_streamer #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 56,
    parameter int IMG_HEIGHT = 56,
    parameter int CHANNEL    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          start,
    input  logic                          ready,
    output logic                          loaded,
    output logic                          busy,
    output logic                          valid_out,
    output logic [CHANNEL*DATA_WIDTH-1:0] data_out,
    output logic                          done,
    output logic                          err
);

    localparam int N    = IMG_WIDTH * IMG_HEIGHT;
    localparam int PX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CH_W = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;
    localparam logic [PX_W-1:0] PX_LAST = PX_W'(N - 1);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNEL - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_LOADED = 2'd2,
        S_STREAM = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Write counter wa is kept split as (channel, pixel) so wa = ch*N + px without a divider.
    logic [CH_W-1:0] wr_ch_q, wr_ch_d;
    logic [PX_W-1:0] wr_px_q, wr_px_d;
    logic [PX_W-1:0] rd_px_q, rd_px_d;

    logic                          valid_q, valid_d;
    logic                          done_q, done_d;
    logic                          err_q, err_d;
    logic [CHANNEL*DATA_WIDTH-1:0] data_q, data_d;

    logic [DATA_WIDTH-1:0] mem_q [CHANNEL][N];

    logic            mem_we;
    logic [CH_W-1:0] ld_ch;
    logic [PX_W-1:0] ld_px;
    logic            ld_last;
    logic            issue;
    logic            frame_last;
    logic            pix_interior;

`ifdef FMAP_STREAMER_PAD_EN
    localparam int ROW_W = $clog2(IMG_HEIGHT + 2);
    localparam int COL_W = $clog2(IMG_WIDTH + 2);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT + 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH + 1);

    // Padded position counters; row/col 0 and *_LAST are the border ring.
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;

    always_comb begin
        pix_interior = (row_q != '0) && (row_q != ROW_LAST) &&
                       (col_q != '0) && (col_q != COL_LAST);
        frame_last   = (row_q == ROW_LAST) && (col_q == COL_LAST);
    end
`else
    always_comb begin
        pix_interior = 1'b1;
        frame_last   = (rd_px_q == PX_LAST);
    end
`endif

    // A load beginning from IDLE or LOADED always writes the word at channel 0, pixel 0.
    always_comb begin
        ld_ch   = (state_q == S_LOAD) ? wr_ch_q : '0;
        ld_px   = (state_q == S_LOAD) ? wr_px_q : '0;
        ld_last = (ld_ch == CH_LAST) && (ld_px == PX_LAST);
    end

    // Stream handshake: a pixel is issued in any STREAM cycle with ready high; its data and
    // valid_out appear one cycle later. ready low stalls the read counter with no skid storage.
    always_comb begin
        state_d = state_q;
        wr_ch_d = wr_ch_q;
        wr_px_d = wr_px_q;
        rd_px_d = rd_px_q;
        err_d   = err_q;
        data_d  = data_q;
        mem_we  = 1'b0;
        issue   = 1'b0;
`ifdef FMAP_STREAMER_PAD_EN
        row_d   = row_q;
        col_d   = col_q;
`endif

        if (state_q == S_STREAM) begin
            if (start || wr_en) begin
                err_d = 1'b1;
            end
            issue = ready;
            if (issue) begin
                for (int c = 0; c < CHANNEL; c++) begin
                    data_d[c*DATA_WIDTH +: DATA_WIDTH] = pix_interior ? mem_q[c][rd_px_q] : '0;
                end
                if (pix_interior) begin
                    rd_px_d = (rd_px_q == PX_LAST) ? '0 : rd_px_q + 1'b1;
                end
`ifdef FMAP_STREAMER_PAD_EN
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
`endif
                if (frame_last) begin
                    state_d = S_LOADED;
                    rd_px_d = '0;
`ifdef FMAP_STREAMER_PAD_EN
                    row_d   = '0;
                    col_d   = '0;
`endif
                end
            end
        end else if (wr_en) begin
            // Loading wins over start in LOADED; any start seen here is a protocol error.
            mem_we = !reset;
            if (start) begin
                err_d = 1'b1;
            end
            if (ld_last) begin
                state_d = S_LOADED;
                wr_ch_d = '0;
                wr_px_d = '0;
            end else begin
                state_d = S_LOAD;
                if (ld_px == PX_LAST) begin
                    wr_px_d = '0;
                    wr_ch_d = ld_ch + 1'b1;
                end else begin
                    wr_px_d = ld_px + 1'b1;
                    wr_ch_d = ld_ch;
                end
            end
        end else if (start) begin
            if (state_q == S_LOADED) begin
                state_d = S_STREAM;
                rd_px_d = '0;
`ifdef FMAP_STREAMER_PAD_EN
                row_d   = '0;
                col_d   = '0;
`endif
            end else begin
                err_d = 1'b1;
            end
        end

        valid_d = issue;
        done_d  = issue && frame_last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            wr_ch_q <= '0;
            wr_px_q <= '0;
            rd_px_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
`ifdef FMAP_STREAMER_PAD_EN
            row_q   <= '0;
            col_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            wr_ch_q <= wr_ch_d;
            wr_px_q <= wr_px_d;
            rd_px_q <= rd_px_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
            data_q  <= data_d;
`ifdef FMAP_STREAMER_PAD_EN
            row_q   <= row_d;
            col_q   <= col_d;
`endif
        end
    end

    // Storage is never cleared; after reset it is simply unreachable until reloaded.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[ld_ch][ld_px] <= wr_data;
        end
    end

    assign loaded    = (state_q == S_LOADED) || (state_q == S_STREAM);
    assign busy      = (state_q == S_LOAD) || (state_q == S_STREAM);
    assign valid_out = valid_q;
    assign done      = done_q;
    assign err       = err_q;
    assign data_out  = data_q;

endmodule
